// File: rtl/id_ex_if.sv
// ID/EX pipeline-register bus: decode-side inputs and execute-side registered outputs.
// master = ID stage driving the slot, slave = the ID/EX register itself.
interface id_ex_if #(
  parameter int WORD_W = 32
);

  logic              flush;
  logic              freeze;
  logic              id_valid;
  logic [3:0]        Exe_Cmd_in;
  logic              mem_read_in;
  logic              mem_write_in;
  logic              WB_Enable_in;
  logic              S_in;
  logic              B_in;
  logic [WORD_W-1:0] PC_in;
  logic [WORD_W-1:0] Val_Rn_in;
  logic [WORD_W-1:0] Val_Rm_in;
  logic              imm_in;
  logic [11:0]       Shift_operand_in;
  logic [23:0]       Signed_imm_24_in;
  logic [3:0]        Dest_in;
  logic [3:0]        src1_in;
  logic [3:0]        src2_in;
  logic              C_in;

  logic              ex_valid;
  logic [3:0]        Exe_Cmd_out;
  logic              mem_read_out;
  logic              mem_write_out;
  logic              WB_Enable_out;
  logic              S_out;
  logic              B_out;
  logic [WORD_W-1:0] PC_out;
  logic [WORD_W-1:0] Val_Rn_out;
  logic [WORD_W-1:0] Val_Rm_out;
  logic              imm_out;
  logic [11:0]       Shift_operand_out;
  logic [23:0]       Signed_imm_24_out;
  logic [3:0]        Dest_out;
  logic [3:0]        src1_out;
  logic [3:0]        src2_out;
  logic              C_out;

  modport master (
    output flush, freeze, id_valid, Exe_Cmd_in, mem_read_in, mem_write_in,
           WB_Enable_in, S_in, B_in, PC_in, Val_Rn_in, Val_Rm_in, imm_in,
           Shift_operand_in, Signed_imm_24_in, Dest_in, src1_in, src2_in, C_in,
    input  ex_valid, Exe_Cmd_out, mem_read_out, mem_write_out, WB_Enable_out,
           S_out, B_out, PC_out, Val_Rn_out, Val_Rm_out, imm_out,
           Shift_operand_out, Signed_imm_24_out, Dest_out, src1_out, src2_out, C_out
  );

  modport slave (
    input  flush, freeze, id_valid, Exe_Cmd_in, mem_read_in, mem_write_in,
           WB_Enable_in, S_in, B_in, PC_in, Val_Rn_in, Val_Rm_in, imm_in,
           Shift_operand_in, Signed_imm_24_in, Dest_in, src1_in, src2_in, C_in,
    output ex_valid, Exe_Cmd_out, mem_read_out, mem_write_out, WB_Enable_out,
           S_out, B_out, PC_out, Val_Rn_out, Val_Rm_out, imm_out,
           Shift_operand_out, Signed_imm_24_out, Dest_out, src1_out, src2_out, C_out
  );

endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush > freeze > load priority and async active-low reset.
// Control bits are gated so an invalid or killed slot can never write back or touch memory.
module id_ex_reg #(
  parameter int WORD_W = 32
) (
  input logic   clk,
  input logic   rst,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [3:0]        exe_cmd;
    logic              mem_read;
    logic              mem_write;
    logic              wb_en;
    logic              s;
    logic              b;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] val_rn;
    logic [WORD_W-1:0] val_rm;
    logic              imm;
    logic [11:0]       shift_op;
    logic [23:0]       simm24;
    logic [3:0]        dest;
    logic [3:0]        src1;
    logic [3:0]        src2;
    logic              c;
  } stage_t;

  typedef enum logic [1:0] {
    ACT_LOAD = 2'd0,
    ACT_HOLD = 2'd1,
    ACT_KILL = 2'd2
  } action_t;

  stage_t  stage_r;
  stage_t  stage_next_s;
  stage_t  load_s;
  action_t action_s;
  logic    rw_conflict_s;

  // Build the load image; control bits only survive for a real instruction.
  always_comb begin
    load_s          = '0;
    rw_conflict_s   = bus.id_valid & bus.mem_read_in & bus.mem_write_in;
    load_s.valid    = bus.id_valid;
    load_s.mem_read = bus.id_valid & bus.mem_read_in;
    load_s.mem_write= bus.id_valid & bus.mem_write_in;
    load_s.wb_en    = bus.id_valid & bus.WB_Enable_in;
    load_s.s        = bus.id_valid & bus.S_in;
    load_s.b        = bus.id_valid & bus.B_in;
    // Branches carry a don't-care ALU command; pin it to a known value.
    if (bus.id_valid && bus.B_in) begin
      load_s.exe_cmd = 4'b0000;
    end else begin
      load_s.exe_cmd = bus.Exe_Cmd_in;
    end
    load_s.pc       = bus.PC_in;
    load_s.val_rn   = bus.Val_Rn_in;
    load_s.val_rm   = bus.Val_Rm_in;
    load_s.imm      = bus.imm_in;
    load_s.shift_op = bus.Shift_operand_in;
    load_s.simm24   = bus.Signed_imm_24_in;
    load_s.dest     = bus.Dest_in;
    load_s.src1     = bus.src1_in;
    load_s.src2     = bus.src2_in;
    load_s.c        = bus.C_in;
  end

  // Pick exactly one action per edge; an illegal read+write load becomes a bubble.
  always_comb begin
    action_s = ACT_LOAD;
    if (bus.flush) begin
      action_s = ACT_KILL;
    end else if (bus.freeze) begin
      action_s = ACT_HOLD;
    end else if (rw_conflict_s) begin
      action_s = ACT_KILL;
    end else begin
      action_s = ACT_LOAD;
    end
  end

  // Next-state mux for the stage contents.
  always_comb begin
    stage_next_s = '0;
    case (action_s)
      ACT_LOAD: stage_next_s = load_s;
      ACT_HOLD: stage_next_s = stage_r;
      ACT_KILL: stage_next_s = '0;
      default:  stage_next_s = '0;
    endcase
  end

  // Stage register; reset clears everything immediately, regardless of freeze/flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_r <= '0;
    end else begin
      stage_r <= stage_next_s;
    end
  end

  assign bus.ex_valid          = stage_r.valid;
  assign bus.Exe_Cmd_out       = stage_r.exe_cmd;
  assign bus.mem_read_out      = stage_r.mem_read;
  assign bus.mem_write_out     = stage_r.mem_write;
  assign bus.WB_Enable_out     = stage_r.wb_en;
  assign bus.S_out             = stage_r.s;
  assign bus.B_out             = stage_r.b;
  assign bus.PC_out            = stage_r.pc;
  assign bus.Val_Rn_out        = stage_r.val_rn;
  assign bus.Val_Rm_out        = stage_r.val_rm;
  assign bus.imm_out           = stage_r.imm;
  assign bus.Shift_operand_out = stage_r.shift_op;
  assign bus.Signed_imm_24_out = stage_r.simm24;
  assign bus.Dest_out          = stage_r.dest;
  assign bus.src1_out          = stage_r.src1;
  assign bus.src2_out          = stage_r.src2;
  assign bus.C_out             = stage_r.c;

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter WORD_W, default 32: width of PC and register-operand paths.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 flush  input  1  taken-branch kill of the incoming ID slot.
REQ-005 freeze  input  1  hazard stall; hold the current contents.
REQ-006 id_valid  input  1  ID slot holds a real instruction.
REQ-007 Exe_Cmd_in  input  4  ALU command from the control unit.
REQ-008 mem_read_in, mem_write_in, WB_Enable_in, S_in, B_in  input  1 each  control-unit decode bits.
REQ-009 PC_in  input  WORD_W  PC+4 of the ID instruction.
REQ-010 Val_Rn_in, Val_Rm_in  input  WORD_W each  register-file read data.
REQ-011 imm_in  input  1  I bit; Shift_operand_in  input  12  operand-2 field; Signed_imm_24_in  input  24  branch offset.
REQ-012 Dest_in  input  4  Rd; src1_in, src2_in  input  4 each  Rn/Rm indices for forwarding.
REQ-013 C_in  input  1  status-register carry at issue.
REQ-014 Each *_in above has a registered *_out counterpart of the same width, plus ex_valid  output  1.

Function
REQ-015 On each rising clk, the block SHALL apply exactly one action, in priority order: flush > freeze > load.
REQ-016 Load: all *_out SHALL take their *_in values, and ex_valid SHALL take id_valid; latency is 1 cycle.
REQ-017 Freeze (flush=0): every output SHALL hold its value; no field changes.
REQ-018 Flush: ex_valid, WB_Enable_out, mem_read_out, mem_write_out, S_out, B_out SHALL be 0 and Exe_Cmd_out SHALL be 4'b0000; all other fields SHALL be 0.
REQ-019 Flush and freeze in the same cycle: flush SHALL win, producing a bubble.
REQ-020 Load with id_valid=0: control bits (WB_Enable, mem_read, mem_write, S, B) SHALL be forced to 0 regardless of their inputs; data fields load normally.
REQ-021 Invariant: when ex_valid=0, WB_Enable_out, mem_read_out, mem_write_out, S_out, B_out SHALL all be 0.
REQ-022 Invariant: mem_read_out and mem_write_out SHALL never both be 1; if both inputs are 1 on load, the block SHALL register a bubble.
REQ-023 Exe_Cmd_in=4'bxxxx on branches SHALL be registered as 4'b0000 whenever B_in=1 and id_valid=1.
REQ-024 C_out SHALL be sampled with the instruction and held under freeze, so an ADC/SBC in EX uses the carry from its issue cycle.
REQ-025 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-026 While rst=0, all outputs SHALL be 0 immediately, without waiting for clk.
REQ-027 Deassertion of rst SHALL take effect at the first rising clk after rst goes high.
REQ-028 Reset asserted during freeze or flush SHALL still clear all state; the held instruction is discarded.

Verification
REQ-029 Load: ADD r3,r1,r2 (Exe_Cmd_in=0011, WB_Enable_in=1, Val_Rn_in=5, Val_Rm_in=7, Dest_in=3, id_valid=1) -> next cycle Exe_Cmd_out=0011, WB_Enable_out=1, Val_Rn_out=5, Val_Rm_out=7, Dest_out=3, ex_valid=1.
REQ-030 Freeze: LDR loaded (mem_read_out=1), then freeze=1 for 3 cycles with changing inputs -> outputs unchanged for all 3 cycles; first edge after freeze=0 loads the new inputs.
REQ-031 Flush priority: flush=1 and freeze=1 with STR in ID -> next cycle ex_valid=0, mem_write_out=0, Exe_Cmd_out=0000.
REQ-032 Bubble and illegal encodings: id_valid=0 with WB_Enable_in=1 -> WB_Enable_out=0; mem_read_in=mem_write_in=1 -> ex_valid=0; B_in=1 with Exe_Cmd_in=xxxx -> Exe_Cmd_out=0000, B_out=1.
REQ-033 Async reset: drive rst=0 mid-cycle while ex_valid=1 -> all outputs are 0 before the next clk; after release, the first edge loads normally.
REQ-034 Carry hold: load ADC with C_in=1, then freeze for 2 cycles with C_in=0 -> C_out stays 1.
